// File: rtl/digital_mash_dsm_pkg.sv
// Shared constants and the noise-cancellation combiner for the MASH delta-sigma modulator.
package digital_mash_dsm_pkg;

  localparam logic [1:0] ORD_BYP = 2'd0;
  localparam logic [1:0] ORD_1   = 2'd1;
  localparam logic [1:0] ORD_2   = 2'd2;
  localparam logic [1:0] ORD_3   = 2'd3;

  localparam int DOUT_W = 4;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic signed [DOUT_W-1:0] dout_t;

  function automatic dout_t bit_ext(input logic b);
    return dout_t'({{(DOUT_W-1){1'b0}}, b});
  endfunction

  // MASH recombination: c1 + (1-z^-1)c2 + (1-z^-1)^2 c3, truncated to the selected order.
  function automatic dout_t mash_combine(input logic [1:0] ord,
                                         input logic c1, input logic c2, input logic c2_d1,
                                         input logic c3, input logic c3_d1, input logic c3_d2);
    dout_t r;
    r = bit_ext(c1);
    if (ord == ORD_2 || ord == ORD_3)
      r = r + bit_ext(c2) - bit_ext(c2_d1);
    if (ord == ORD_3)
      r = r + bit_ext(c3) - (bit_ext(c3_d1) <<< 1) + bit_ext(c3_d2);
    if (ord == ORD_BYP)
      r = '0;
    return r;
  endfunction

endpackage

// File: rtl/digital_mash_dsm_stage.sv
// W-bit accumulator stage: combinational sum/carry of acc+din+cin, registered acc with clear.
module dsm_acc_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         cin,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W-1:0] acc;
  logic [W:0]   s;

  assign s     = {1'b0, acc} + {1'b0, din} + {{W{1'b0}}, cin};
  assign sum   = s[W-1:0];
  // A cleared stage reports no overflow so downstream delays stay zero.
  assign carry = s[W] & ~clr;

  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (en)
      acc <= clr ? '0 : sum;
  end

endmodule

// File: rtl/digital_mash_dsm.sv
// MASH 1-1-1 delta-sigma modulator with selectable order, LFSR LSB dither and signed 4-bit output.
module digital_mash_dsm
  import digital_mash_dsm_pkg::*;
#(
  parameter int          W         = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [W-1:0]      alpha,
  input  logic [1:0]        order,
  input  logic              dither_en,
  output logic signed [3:0] dout,
  output logic              dout_valid
);

  logic [15:0]  lfsr;
  logic         d;
  logic         clr1, clr2, clr3;
  logic [W-1:0] sum1, sum2, sum3;
  logic         c1, c2, c3;
  logic         c2_d1, c3_d1, c3_d2;

  assign d    = dither_en & lfsr[0];
  assign clr1 = (order == ORD_BYP);
  assign clr2 = (order == ORD_BYP) || (order == ORD_1);
  assign clr3 = (order != ORD_3);

  dsm_acc_stage #(.W(W)) u_st1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr1), .cin(d),
    .din(alpha), .sum(sum1), .carry(c1)
  );

  dsm_acc_stage #(.W(W)) u_st2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr2), .cin(1'b0),
    .din(sum1), .sum(sum2), .carry(c2)
  );

  dsm_acc_stage #(.W(W)) u_st3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr3), .cin(1'b0),
    .din(sum2), .sum(sum3), .carry(c3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= LFSR_SEED;
      c2_d1      <= 1'b0;
      c3_d1      <= 1'b0;
      c3_d2      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= en;
      if (en) begin
        if (dither_en)
          lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        c2_d1 <= clr2 ? 1'b0 : c2;
        c3_d1 <= clr3 ? 1'b0 : c3;
        c3_d2 <= clr3 ? 1'b0 : c3_d1;
        dout  <= mash_combine(order, c1, c2, c2_d1, c3, c3_d1, c3_d2);
      end
    end
  end

  // Final-stage sum is not needed beyond its carry.
  logic unused_sum3;
  assign unused_sum3 = ^sum3;

endmodule

// File: doc/digital_mash_dsm.md
DIGITAL_MASH_DSM -- requirements
Module: digital_mash_dsm

Interface
REQ-001 Parameter W, default 16, is the accumulator and fractional-word width in bits; legal range is 8..32.
REQ-002 Parameter LFSR_SEED, default 16'hACE1, is the non-zero reset value of the dither LFSR.
REQ-003 clk  input  1  is the single clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  is the reset; it is synchronous and active-high.
REQ-005 en  input  1  is the clock enable; the modulator advances only on edges where en=1.
REQ-006 alpha  input  W  is the unsigned fraction; the target mean output is alpha/2^W.
REQ-007 order  input  2  is the order select: 0 = bypass, 1 = first order, 2 = MASH 1-1, 3 = MASH 1-1-1.
REQ-008 dither_en  input  1  enables LSB dither on the stage-1 input.
REQ-009 dout  output  4  is the signed two's-complement divider offset.
REQ-010 dout_valid  output  1  is high for one cycle after each enabled edge.

Function
REQ-011 On each enabled edge, stage 1 SHALL compute s1 = acc1 + alpha + d (W+1 bits), c1 = s1[W], acc1 <= s1[W-1:0]; d = lfsr[0] when dither_en=1, else 0.
REQ-012 Stage 2 SHALL compute s2 = acc2 + s1[W-1:0], c2 = s2[W], acc2 <= s2[W-1:0]; stage 3 SHALL do the same with acc3 and s2[W-1:0].
REQ-013 Delay registers c2_d1, c3_d1 and c3_d2 SHALL hold the previous carries (c3_d2 is c3 two enabled edges ago) and SHALL update only on enabled edges.
REQ-014 The registered output SHALL be dout <= c1 for order=1; c1 + c2 - c2_d1 for order=2; and c1 + c2 - c2_d1 + c3 - 2*c3_d1 + c3_d2 for order=3.
REQ-015 order=0 SHALL hold all accumulators at 0 and drive dout=0; dout_valid still pulses.
REQ-016 The dout range SHALL be 0..1 for order 1, -1..+2 for order 2 and -3..+4 for order 3; a 4-bit signed word SHALL represent every value without overflow.
REQ-017 Latency: dout and dout_valid SHALL reflect the edge at which alpha was sampled, and are visible after that edge (one register stage).
REQ-018 With en=0, all state SHALL hold, dout SHALL hold its last value and dout_valid SHALL be 0.
REQ-019 Stages above the selected order SHALL be cleared (acc, carries and delays = 0) on every enabled edge, so that a mid-run order change leaves no stale state.
REQ-020 The LFSR SHALL be 16-bit Fibonacci with taps 16,14,13,11; it SHALL advance on enabled edges only when dither_en=1 and SHALL never reach the all-zero state.
REQ-021 Accumulator wrap-around is modulo 2^W; the carry out is the only overflow indication.
REQ-022 alpha and order changes SHALL take effect on the next enabled edge, with no pipeline bubble.

Reset
REQ-023 When rst=1 at an edge, the block SHALL clear acc1..acc3, all carry-delay registers, dout (0) and dout_valid (0), and SHALL load the LFSR with LFSR_SEED.
REQ-024 rst SHALL take priority over en.
REQ-025 Reset mid-operation SHALL produce, after release, the same output sequence as from power-on reset.

Structure
REQ-026 A shared package SHALL hold the order-encoding constants (ORD_BYP, ORD_1, ORD_2, ORD_3), the DOUT_W=4 constant and the LFSR tap mask.
REQ-027 One sub-module, dsm_acc_stage (W-bit accumulator with carry out, enable and clear), SHALL be instantiated three times.
REQ-028 The noise-cancellation combiner and the LFSR SHALL live in the top level.

Verification
REQ-029 order=3, alpha=0, dither off, 100 cycles -> dout=0 on every cycle.
REQ-030 order=1, W=16, alpha=16'h8000, dither off, from reset -> dout = 0,1,0,1,... starting on the first valid cycle.
REQ-031 order=3, W=16, alpha=16'h4000, 65536 enabled cycles -> sum of dout = 16384 and every dout value lies in -3..+4.
REQ-032 order=2, alpha=16'h5555, toggle en low for 10 cycles mid-run -> dout_valid=0 and dout frozen during the gap; the sequence resumes identically to a gap-free run.
REQ-033 rst asserted at cycle 500 of an order-3 run with dither on -> the post-release dout and LFSR sequence matches the first 500 cycles exactly.
REQ-034 Switch order 3->1 mid-run -> acc2, acc3 and the delay registers read 0 after the next enabled edge, and dout is in 0..1 thereafter.
